// File: rtl/mx_alu_src_a_pkg.sv
// Shared CPU datapath definitions: ALUSrcA encodings and default data width.
package mx_alu_src_a_pkg;

    localparam int DATA_W = 32;

    localparam logic ALU_SRC_A_PC  = 1'b0;
    localparam logic ALU_SRC_A_REG = 1'b1;

endpackage

// File: rtl/mx_alu_src_a_mux2_w.sv
// Generic WIDTH-bit 2:1 mux; shared by the ALUSrcA/ALUSrcB/MemtoReg/RegDst paths.
module mux2_w #(
    parameter int WIDTH = 32
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = in0;
        if (sel) begin
            out = in1;
        end
    end

endmodule

// File: rtl/mx_alu_src_a.sv
// ALU operand-A source select (PC or register A), with a registered copy
// of the selected operand for the ALUOut/trace path.
module mx_alu_src_a
    import mx_alu_src_a_pkg::*;
#(
    parameter int               WIDTH     = DATA_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ALUSrcA,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             hold,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q
);

    logic sel_reg;

    assign sel_reg = (ALUSrcA == ALU_SRC_A_REG);

    mux2_w #(
        .WIDTH (WIDTH)
    ) u_mux (
        .sel (sel_reg),
        .in0 (in0),
        .in1 (in1),
        .out (out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= RESET_VAL;
        end else if (!hold) begin
            out_q <= out;
        end
    end

`ifndef SYNTHESIS
    // An unknown select would silently pick in0 in the mux; catch it in simulation.
    a_sel_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(ALUSrcA))
        else $error("mx_alu_src_a: ALUSrcA is X/Z while out of reset");
`endif

endmodule

// File: tb/tb_mx_alu_src_a.sv
// Self-checking bench for mx_alu_src_a: directed cases plus randomized traffic
// compared every cycle against a behavioural mux/register model.
module tb_mx_alu_src_a;

    localparam int          W  = 32;
    localparam logic [31:0] RV = 32'h0000_0000;

    logic         clk;
    logic         rst;
    logic         ALUSrcA;
    logic [W-1:0] in0;
    logic [W-1:0] in1;
    logic         hold;
    logic [W-1:0] out;
    logic [W-1:0] out_q;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;

    logic [W-1:0] model_q;

    mx_alu_src_a #(
        .WIDTH     (W),
        .RESET_VAL (RV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ALUSrcA (ALUSrcA),
        .in0     (in0),
        .in1     (in1),
        .hold    (hold),
        .out     (out),
        .out_q   (out_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_mux(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        return s ? b : a;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst)
            model_q <= RV;
        else if (!hold)
            model_q <= ref_mux(ALUSrcA, in0, in1);
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_out", out, ref_mux(ALUSrcA, in0, in1));
            chk("cyc_out_q", out_q, model_q);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ALUSrcA = 1'b0; in0 = '0; in1 = '0; hold = 1'b0;
        #100;
        chk("reset_out", out, 32'h0);
        chk("reset_out_q", out_q, 32'h0);
        cmp_en = 1;

        step();
        rst = 1'b0;
        in0 = 32'h1234_5678;
        step();
        chk("load_1234", out_q, 32'h1234_5678);
        #2 rst = 1'b1;
        #1 chk("async_rst", out_q, 32'h0);
        step();
        chk("rst_hold", out_q, 32'h0);
        rst = 1'b0;

        ALUSrcA = 1'b0; in0 = 32'h0040_0004; in1 = 32'hDEAD_BEEF;
        #1 chk("pc_out", out, 32'h0040_0004);
        step();
        chk("pc_out_q", out_q, 32'h0040_0004);

        ALUSrcA = 1'b1;
        #1 chk("rega_out", out, 32'hDEAD_BEEF);
        step();
        chk("rega_out_q", out_q, 32'hDEAD_BEEF);

        in0 = 32'hFFFF_FFFF; in1 = 32'h8000_0000;
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] e;
            ALUSrcA = i[0];
            e = i[0] ? 32'h8000_0000 : 32'hFFFF_FFFF;
            #1 chk("ext_out", out, e);
            step();
            chk("ext_out_q", out_q, e);
        end

        ALUSrcA = 1'b0; in0 = 32'h0000_00AA;
        step();
        chk("hold_pre", out_q, 32'h0000_00AA);
        hold = 1'b1; ALUSrcA = 1'b1; in1 = 32'h0000_0055;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_out", out, 32'h0000_0055);
            chk("hold_out_q", out_q, 32'h0000_00AA);
        end
        hold = 1'b0;
        step();
        chk("hold_rel", out_q, 32'h0000_0055);

        for (int i = 0; i < 1000; i++) begin
            ALUSrcA = 1'($urandom_range(0, 1));
            in0     = $urandom;
            in1     = $urandom;
            hold    = ($urandom_range(0, 3) == 0);
            rst     = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0;
        step();
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mx_alu_src_a.md
Name: mx_alu_src_a

Overview:
ALU operand-A source multiplexer for the multicycle CPU datapath. It selects between the PC value (in0) and the register-file A latch (in1) under control of ALUSrcA, and drives the ALU's A input combinationally. It also provides a registered copy of the selected operand for the ALUOut/trace path. It sits between the PC/A registers and the ALU.

Parameters:
WIDTH, 32, data width of in0, in1, out, out_q
RESET_VAL, 32'h0000_0000, value loaded into out_q on reset

Ports:
clk  input  1  system clock; out_q samples on rising edge
rst  input  1  asynchronous reset, active-high
ALUSrcA  input  1  source select: 0 selects in0 (PC), 1 selects in1 (register A)
in0  input  WIDTH  operand candidate 0 (PC)
in1  input  WIDTH  operand candidate 1 (register A latch)
hold  input  1  1 = out_q keeps its value; 0 = out_q loads the current selection
out  output  WIDTH  combinational selected operand to the ALU A input
out_q  output  WIDTH  registered selected operand

Behaviour:
- Clocking: one clock (clk). Reset rst is asynchronous and active-high.
- out is purely combinational with zero latency.
  - out = in1 when ALUSrcA = 1; out = in0 otherwise.
  - out does not depend on clk, rst or hold.
  - out is valid during reset.
- out_q:
  - On rst assertion, out_q = RESET_VAL immediately, with no clock needed.
  - While rst is high, out_q holds RESET_VAL regardless of the other inputs.
  - After rst deasserts, on each rising clk: if hold = 0, out_q <= current out; if hold = 1, out_q is unchanged.
  - Latency from an input change to out_q is one clock edge.
- Simultaneous events:
  - rst dominates hold and the clock edge.
  - A select and data change in the same cycle is captured as a single consistent mux result at the edge.
- Full-width pass-through: no sign extension, truncation or arithmetic. All WIDTH bits are routed unmodified, including bit WIDTH-1 and the all-ones pattern.
- No internal state other than out_q.
- No latches: the combinational path is fully specified for both select values.
- Simulation-only check (excluded from synthesis): flag an error if ALUSrcA is X/Z while rst is low.

Decomposition:
- Shared CPU package holds:
  - ALU_SRC_A_PC = 1'b0 and ALU_SRC_A_REG = 1'b1 encodings, used by the control FSM and this block;
  - DATA_W = 32.
- Sub-module: mux2_w (generic WIDTH-bit 2:1 mux) for the combinational path, reusable by the ALUSrcB/MemtoReg/RegDst muxes.
- The out_q register stays in this module.

Test Plan:
1. Reset/idle: rst = 1, ALUSrcA = 0, in0 = 0, in1 = 0, hold = 0 for 100 ns -> out = 0 and out_q = 0. Then assert rst mid-cycle after out_q = 32'h1234_5678 -> out_q = 0 immediately, without a clock edge.
2. Select PC: ALUSrcA = 0, in0 = 32'h0040_0004, in1 = 32'hDEAD_BEEF -> out = 32'h0040_0004 in the same delta; out_q = 32'h0040_0004 after the next rising clk.
3. Select register A: ALUSrcA = 1 with the same inputs -> out = 32'hDEAD_BEEF combinationally; out_q = 32'hDEAD_BEEF after one edge.
4. Width extremes: in0 = 32'hFFFF_FFFF, in1 = 32'h8000_0000, toggle ALUSrcA 0/1 each cycle -> out alternates exactly between those values; out_q follows one cycle later.
5. Hold: out_q = 32'h0000_00AA, then hold = 1, change to ALUSrcA = 1, in1 = 32'h55 for 3 clocks -> out = 32'h55 while out_q stays 32'hAA. Release hold -> out_q = 32'h55 after one edge.
6. Randomized: 1000 cycles of random ALUSrcA/in0/in1/hold -> out matches the reference mux every cycle; out_q matches the modelled register every edge.
